// File: rtl/cond_pkg.sv
// Shared types for the condition/flag unit: ARM condition codes, NZCV bit positions
// and flag-write selects.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

  localparam int unsigned N_B = 3;
  localparam int unsigned Z_B = 2;
  localparam int unsigned C_B = 1;
  localparam int unsigned V_B = 0;

  typedef enum logic [1:0] {
    FW_NONE = 2'b00,
    FW_CV   = 2'b01,
    FW_NZ   = 2'b10,
    FW_ALL  = 2'b11
  } flagw_e;

  typedef struct packed {
    logic valid;
    logic pcs;
    logic regw;
    logic memw;
    logic cond_ex;
    logic illegal;
  } out_t;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decodes a 4-bit condition field against NZCV.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[N_B];
  assign z = flags[Z_B];
  assign c = flags[C_B];
  assign v = flags[V_B];

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond_e'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = ~z;
      CS: cond_ex = c;
      CC: cond_ex = ~c;
      MI: cond_ex = n;
      PL: cond_ex = ~n;
      VS: cond_ex = v;
      VC: cond_ex = ~v;
      HI: cond_ex = c & ~z;
      LS: cond_ex = ~c | z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = ~z & (n == v);
      LE: cond_ex = z | (n != v);
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Architectural NZCV register, condition gating of PCSrc/RegWrite/MemWrite and a
// saturating count of squashed instructions.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       cond,
  input  logic [1:0]       flag_w,
  input  logic [3:0]       alu_flags,
  input  logic             pcs_in,
  input  logic             regw_in,
  input  logic             memw_in,
  input  logic             no_write,
  output logic             valid_out,
  output logic             pcs_out,
  output logic             regw_out,
  output logic             memw_out,
  output logic             cond_ex_q,
  output logic             illegal_cond,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] squash_cnt
);

  logic             cond_ex;
  logic             issue;
  logic             live;
  logic [3:0]       flags_d;
  logic [CNT_W-1:0] cnt_d;
  out_t             out_d;
  out_t             out_q;

  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  assign issue = valid_in & ~flush;
  assign live  = issue & ~stall;

  // Flags only move on a live, executing instruction; the condition always sees pre-edge flags.
  always_comb begin
    flags_d = flags_q;
    if (live && cond_ex) begin
      if (flag_w[1]) begin
        flags_d[N_B] = alu_flags[N_B];
        flags_d[Z_B] = alu_flags[Z_B];
      end
      if (flag_w[0]) begin
        flags_d[C_B] = alu_flags[C_B];
        flags_d[V_B] = alu_flags[V_B];
      end
    end
  end

  always_comb begin
    cnt_d = squash_cnt;
    if (live && !cond_ex && (squash_cnt != {CNT_W{1'b1}})) begin
      cnt_d = squash_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    out_d         = '0;
    out_d.valid   = issue;
    out_d.cond_ex = cond_ex & issue;
    out_d.pcs     = pcs_in & cond_ex & issue;
    out_d.regw    = regw_in & ~no_write & cond_ex & issue;
    out_d.memw    = memw_in & cond_ex & issue;
    out_d.illegal = issue & (cond == 4'hF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= 4'b0000;
      squash_cnt <= '0;
      out_q      <= '0;
    end else begin
      flags_q    <= flags_d;
      squash_cnt <= cnt_d;
      if (!stall) begin
        out_q <= out_d;
      end
    end
  end

  assign valid_out    = out_q.valid;
  assign pcs_out      = out_q.pcs;
  assign regw_out     = out_q.regw;
  assign memw_out     = out_q.memw;
  assign cond_ex_q    = out_q.cond_ex;
  assign illegal_cond = out_q.illegal;

endmodule
